// File: rtl/board_stream_reader.sv
// board_stream_reader
//   Read-side counterpart of the board register array. On a start request it
//   snapshots the packed 64x4 board and streams it out one byte per
//   transfer over a valid/ready interface.
//   Frame: HEADER_BYTE, NUM_SQ square bytes {4'h0, square}, optional checksum.
//
// Configuration macro: BOARD_STREAM_CHECKSUM_EN
//   defined   -> frame ends with the 8-bit modular sum of the square bytes
//   undefined -> no checksum state or sum register; frame ends after the last square
//
// Ports
//   clk              system clock (25 MHz domain)
//   rst_n            asynchronous active-low reset
//   board            packed board, square i = board[i*4+3:i*4]
//   board_change_en  board write strobe, only used to flag a stale frame
//   start            1-cycle frame request (ignored unless idle)
//   tx_data/tx_valid stream byte and its valid flag
//   tx_ready         sink accepts when tx_valid && tx_ready
//   busy             high while the frame is being sent
//   done             1-cycle pulse after the last byte transfers
//   stale            board was written while busy; cleared by the next accepted start
module board_stream_reader #(
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter int         NUM_SQ      = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SQ*4-1:0] board,
  input  logic                board_change_en,
  input  logic                start,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done,
  output logic                stale
);

  localparam int IDX_W = $clog2(NUM_SQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SQ - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SQ   = 3'd2,
`ifdef BOARD_STREAM_CHECKSUM_EN
    CSUM = 3'd3,
`endif
    FIN  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [NUM_SQ*4-1:0] snapshot;
  logic [IDX_W-1:0]    index;
  logic [3:0]          cur_sq;
  logic                xfer;
`ifdef BOARD_STREAM_CHECKSUM_EN
  logic [7:0]          sum;
`endif

  assign xfer   = tx_valid && tx_ready;
  // {index, 2'b00} is index*4 without widening to a 32-bit product
  assign cur_sq = snapshot[{index, 2'b00} +: 4];

  // State register; reset drops the stream immediately since outputs decode state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = HDR;
      HDR:  if (xfer)  state_next = SQ;
      SQ: begin
        if (xfer && index == LAST_IDX) begin
`ifdef BOARD_STREAM_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = FIN;
`endif
        end
      end
`ifdef BOARD_STREAM_CHECKSUM_EN
      CSUM: if (xfer) state_next = FIN;
`endif
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; tx_data only depends on state/index/snapshot, so it holds during stalls
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_BYTE;
        busy     = 1'b1;
      end
      SQ: begin
        tx_valid = 1'b1;
        tx_data  = {4'h0, cur_sq};
        busy     = 1'b1;
      end
`ifdef BOARD_STREAM_CHECKSUM_EN
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = sum;
        busy     = 1'b1;
      end
`endif
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // Snapshot, square index, running sum and staleness flag.
  // A write coinciding with the accepted start is not flagged: the snapshot
  // taken that cycle holds the pre-write board.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot <= '0;
      index    <= '0;
      stale    <= 1'b0;
`ifdef BOARD_STREAM_CHECKSUM_EN
      sum      <= 8'h00;
`endif
    end else if (state == IDLE && start) begin
      snapshot <= board;
      index    <= '0;
      stale    <= 1'b0;
`ifdef BOARD_STREAM_CHECKSUM_EN
      sum      <= 8'h00;
`endif
    end else begin
      if (busy && board_change_en) stale <= 1'b1;
      if (state == SQ && xfer) begin
        index <= index + 1'b1;
`ifdef BOARD_STREAM_CHECKSUM_EN
        sum   <= sum + tx_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_board_stream_reader.sv
// Testbench for board_stream_reader. A queue-based frame model predicts the
// byte stream, busy, done and stale every cycle; literal expectations from
// the hand-worked initial-board frame pin the model itself.
module tb_board_stream_reader;

  localparam int NUM_SQ = 64;
`ifdef BOARD_STREAM_CHECKSUM_EN
  localparam int FRAME_LEN = 66;
`else
  localparam int FRAME_LEN = 65;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NUM_SQ*4-1:0] board;
  logic                board_change_en;
  logic                start;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                busy;
  logic                done;
  logic                stale;

  int errors = 0;
  int checks = 0;

  logic [7:0] expQ[$];
  logic [7:0] capQ[$];
  bit         expDone;
  bit         expStale;
  bit         expBusy;
  bit         newDone;
  int         doneCount;
  int         busyCycles;
  int         doneBefore;

  board_stream_reader #(.HEADER_BYTE(8'hA5), .NUM_SQ(NUM_SQ)) dut (
    .clk(clk), .rst_n(rst_n), .board(board), .board_change_en(board_change_en),
    .start(start), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .stale(stale)
  );

  always #20 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [NUM_SQ*4-1:0] initBoard();
    logic [NUM_SQ*4-1:0] b;
    logic [2:0] back[8];
    back = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[i*4 +: 4]      = {1'b1, back[i]};
      b[(8+i)*4 +: 4]  = 4'h9;
      b[(48+i)*4 +: 4] = 4'h1;
      b[(56+i)*4 +: 4] = {1'b0, back[i]};
    end
    return b;
  endfunction

  // Expected frame built from the board as seen on the accepted start cycle
  task automatic buildFrame();
    logic [7:0] s;
    logic [7:0] b;
    s = 8'h00;
    expQ.delete();
    expQ.push_back(8'hA5);
    for (int i = 0; i < NUM_SQ; i++) begin
      b = {4'h0, board[i*4 +: 4]};
      expQ.push_back(b);
      s = s + b;
    end
`ifdef BOARD_STREAM_CHECKSUM_EN
    expQ.push_back(s);
`endif
  endtask

  // Compare process: outputs are sampled on the falling edge, then the
  // model advances using the inputs the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      expDone  = 1'b0;
      expStale = 1'b0;
    end else begin
      expBusy = (expQ.size() != 0);
      checkOutput("tx_valid", {31'd0, tx_valid}, {31'd0, expBusy});
      checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
      checkOutput("done", {31'd0, done}, {31'd0, expDone});
      checkOutput("stale", {31'd0, stale}, {31'd0, expStale});
      if (expBusy) checkOutput("tx_data", {24'd0, tx_data}, {24'd0, expQ[0]});
      if (busy) busyCycles++;
      if (done) doneCount++;
      if (tx_valid && tx_ready) capQ.push_back(tx_data);
      newDone = 1'b0;
      if (expBusy) begin
        if (board_change_en) expStale = 1'b1;
        if (tx_ready) begin
          void'(expQ.pop_front());
          if (expQ.size() == 0) newDone = 1'b1;
        end
      end else if (!expDone && start) begin
        buildFrame();
        expStale = 1'b0;
      end
      expDone = newDone;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic bce);
    start           = s;
    tx_ready        = r;
    board_change_en = bce;
  endtask

  task automatic waitDone(input int budget, input bit randReady);
    int base;
    int n;
    base = doneCount;
    n = 0;
    while (doneCount == base && n < budget) begin
      if (randReady) tx_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    tx_ready = 1'b1;
    if (doneCount == base) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitBytes(input int count, input int budget);
    int n;
    n = 0;
    while (capQ.size() < count && n < budget) begin
      tick();
      n++;
    end
    if (capQ.size() < count) checkOutput("bytes_timeout", capQ.size(), count);
  endtask

  task automatic startFrame();
    capQ.delete();
    busyCycles = 0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    board = initBoard();
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("reset_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_stale", {31'd0, stale}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Initial board, sink always ready
    startFrame();
    checkOutput("t1_latency_valid", {31'd0, tx_valid}, 32'd1);
    waitDone(200, 1'b0);
    tick();
    checkOutput("t1_len", capQ.size(), FRAME_LEN);
    checkOutput("t1_hdr", {24'd0, capQ[0]}, 32'hA5);
    checkOutput("t1_sq0", {24'd0, capQ[1]}, 32'h0C);
    checkOutput("t1_sq4", {24'd0, capQ[5]}, 32'h0E);
    checkOutput("t1_sq8", {24'd0, capQ[9]}, 32'h09);
    checkOutput("t1_sq30", {24'd0, capQ[31]}, 32'h00);
    checkOutput("t1_sq48", {24'd0, capQ[49]}, 32'h01);
    checkOutput("t1_sq63", {24'd0, capQ[64]}, 32'h04);
`ifdef BOARD_STREAM_CHECKSUM_EN
    checkOutput("t1_csum", {24'd0, capQ[65]}, 32'hCA);
`endif
    checkOutput("t1_busy_cycles", busyCycles, FRAME_LEN);

    // Same frame, sink stalling at random
    startFrame();
    waitDone(2000, 1'b1);
    tick();
    checkOutput("t2_len", capQ.size(), FRAME_LEN);
    checkOutput("t2_sq63", {24'd0, capQ[64]}, 32'h04);

    // Board write during the frame: snapshot holds, stale is flagged
    startFrame();
    waitBytes(10, 200);
    board[3:0] = 4'h0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitDone(200, 1'b0);
    tick();
    checkOutput("t3_sq0_snapshot", {24'd0, capQ[1]}, 32'h0C);
    checkOutput("t3_stale_set", {31'd0, stale}, 32'd1);
    startFrame();
    checkOutput("t3_stale_cleared", {31'd0, stale}, 32'd0);
    waitDone(200, 1'b0);
    tick();
    checkOutput("t3_sq0_new", {24'd0, capQ[1]}, 32'h00);
    board = initBoard();

    // Start pulses mid-frame and during FIN are ignored
    doneBefore = doneCount;
    startFrame();
    waitBytes(5, 200);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 200 && done !== 1'b1; n++) tick();
    checkOutput("t4_fin_reached", {31'd0, done}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("t4_fin_start_ignored", {31'd0, tx_valid}, 32'd0);
    checkOutput("t4_one_frame_len", capQ.size(), FRAME_LEN);
    checkOutput("t4_one_done", doneCount - doneBefore, 32'd1);
    capQ.delete();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t4_restart_valid", {31'd0, tx_valid}, 32'd1);
    waitDone(200, 1'b0);
    tick();
    checkOutput("t4_restart_len", capQ.size(), FRAME_LEN);

    // Reset mid-frame abandons the frame without a done pulse
    startFrame();
    waitBytes(20, 200);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitBytes(31, 200);
    checkOutput("t5_stale_before_reset", {31'd0, stale}, 32'd1);
    doneBefore = doneCount;
    #5;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("t5_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_rst_stale", {31'd0, stale}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("t5_no_done", doneCount - doneBefore, 32'd0);
    startFrame();
    waitDone(200, 1'b0);
    tick();
    checkOutput("t5_after_len", capQ.size(), FRAME_LEN);
    checkOutput("t5_after_sq63", {24'd0, capQ[64]}, 32'h04);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
